mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: the MEM stage proper. Turns latched EX/MEM
//  control/data into a data-cache request handshake (REN/WEN/addr/store <-> dhit/load).
//  Drives stall back to every upstream pipeline register's WEN while a request is outstanding.
//  Contains the MEM/WB register feeding writeback.
// PARAMETERS
//  WORD_W    32   data/address width
//  REGSEL_W  5    register-select width
//  TIMEOUT   64   wait cycles before err_timeout is raised (>=2)
// PORTS
//  CLK            in   1         clock, rising edge
//  nRST           in   1         reset, asynchronous, active-low
//  flush          in   1         kill the current MEM-stage instruction
//  mem_read_in    in   1         EX/MEM M_MemRead
//  mem_write_in   in   1         EX/MEM M_MemWrite
//  mem_to_reg_in  in   1         EX/MEM WB_MemToReg
//  reg_write_in   in   1         EX/MEM WB_RegWrite
//  alu_output_in  in   WORD_W    EX/MEM ALU result / memory address
//  rdat2_in       in   WORD_W    EX/MEM store data
//  reg_dst_in     in   REGSEL_W  EX/MEM destination (rd or rt)
//  dmemREN        out  1         cache read request
//  dmemWEN        out  1         cache write request
//  dmemaddr       out  WORD_W    cache address (= alu_output_in)
//  dmemstore      out  WORD_W    cache store data (= rdat2_in)
//  dhit           in   1         cache completes request this cycle
//  dmemload       in   WORD_W    cache load data, valid when dhit
//  stall          out  1         hold upstream pipeline registers (their WEN = !stall)
//  wb_reg_write   out  1         MEM/WB RegWrite
//  wb_wsel        out  REGSEL_W  MEM/WB destination register
//  wb_wdat        out  WORD_W    MEM/WB write-back data
//  err_timeout    out  1         sticky: request waited >= TIMEOUT cycles
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0, all outputs 0 (wb_*, err_timeout registered; REN/WEN/stall
//   are 0 combinationally in IDLE with no request).
//  req = (mem_read_in | mem_write_in) & !flush. Both read and write set: write only, REN=0.
//  dmemREN/dmemWEN combinational from req in IDLE and WAIT; addr/store pass through.
//  stall = req & !dhit (same cycle; a hit on the first cycle produces zero stall).
//  FSM IDLE: req & !dhit -> WAIT, wait_cnt<=1; req & dhit -> IDLE (1-cycle access).
//  FSM WAIT: request held (upstream frozen by stall); dhit -> IDLE, wait_cnt<=0;
//   else wait_cnt++ (saturating at TIMEOUT); wait_cnt reaching TIMEOUT sets err_timeout
//   (sticky until nRST); stall stays asserted, no forced completion.
//  flush: REN/WEN/stall drop same cycle; state<=IDLE, wait_cnt<=0; MEM/WB gets a bubble.
//  MEM/WB update every edge:
//   stall | flush -> wb_reg_write<=0 (bubble), wb_wsel/wb_wdat hold.
//   else wb_reg_write<=reg_write_in, wb_wsel<=reg_dst_in,
//        wb_wdat<= mem_to_reg_in ? dmemload : alu_output_in.
//  Latency: non-memory op -> WB next edge; load hit in cycle N -> WB valid in cycle N+1.
//  dhit with no req is ignored. nRST mid-WAIT: immediate abort, all state to reset values.
// TESTING
//  1 Load hit: read=1,addr=0x100,dhit=1,dmemload=0xDEADBEEF,m2r=1,dst=5 -> REN=1,stall=0;
//    next cycle wb_reg_write=1,wb_wsel=5,wb_wdat=0xDEADBEEF.
//  2 Store, 3 wait: write=1,addr=0x40,rdat2=0x1234,dhit on 4th cycle -> WEN=1 4 cycles,
//    store=0x1234, stall=1 3 cycles, wb_reg_write=0 throughout.
//  3 ALU op: alu_output=0x55,reg_write=1,dst=9, no mem -> REN=WEN=stall=0; next wb_wdat=0x55.
//  4 Timeout: TIMEOUT=8, read, dhit=0 -> err_timeout=1 after 8 wait cycles, stall stays 1;
//    later dhit clears stall, err_timeout stays 1.
//  5 Flush in WAIT (cycle 2): REN=0,stall=0 same cycle; next wb_reg_write=0, state IDLE.
//  6 nRST low mid-WAIT: REN=0,stall=0,wb_*=0,err_timeout=0 immediately, before next edge.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: consumes the EX/MEM register, drives the data-cache
// request handshake, freezes upstream registers while a request is outstanding,
// and holds the MEM/WB register that feeds writeback.
module mem_access_unit #(
    parameter int WORD_W   = 32,
    parameter int REGSEL_W = 5,
    parameter int TIMEOUT  = 64
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                flush,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                mem_to_reg_in,
    input  logic                reg_write_in,
    input  logic [WORD_W-1:0]   alu_output_in,
    input  logic [WORD_W-1:0]   rdat2_in,
    input  logic [REGSEL_W-1:0] reg_dst_in,
    output logic                dmemREN,
    output logic                dmemWEN,
    output logic [WORD_W-1:0]   dmemaddr,
    output logic [WORD_W-1:0]   dmemstore,
    input  logic                dhit,
    input  logic [WORD_W-1:0]   dmemload,
    output logic                stall,
    output logic                wb_reg_write,
    output logic [REGSEL_W-1:0] wb_wsel,
    output logic [WORD_W-1:0]   wb_wdat,
    output logic                err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_waitCntNext;
    logic             w_req;

    // A request exists whenever EX/MEM asks for memory and the instruction is not
    // being killed; gating with nRST keeps the handshake quiet during reset even
    // if upstream still presents a memory op.
    assign w_req     = (mem_read_in | mem_write_in) & ~flush & nRST;
    assign dmemWEN   = w_req & mem_write_in;
    assign dmemREN   = w_req & mem_read_in & ~mem_write_in;
    assign stall     = w_req & ~dhit;
    assign dmemaddr  = alu_output_in;
    assign dmemstore = rdat2_in;

    // State and wait-counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
        end
    end

    // Next state: enter WAIT on a missed first cycle, count wait cycles saturating
    // at TIMEOUT, and fall back to IDLE on a hit or when the request vanishes.
    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = r_waitCnt;
        case (r_state)
            IDLE: begin
                if (w_req && !dhit) begin
                    w_stateNext   = WAIT;
                    w_waitCntNext = CNT_W'(1);
                end else begin
                    w_waitCntNext = '0;
                end
            end
            WAIT: begin
                if (!w_req || dhit) begin
                    w_stateNext   = IDLE;
                    w_waitCntNext = '0;
                end else if (r_waitCnt != TIMEOUT_C) begin
                    w_waitCntNext = r_waitCnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_waitCntNext = '0;
            end
        endcase
    end

    // Sticky timeout flag: latches once the wait count reaches TIMEOUT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_timeout <= 1'b0;
        end else if (w_waitCntNext == TIMEOUT_C) begin
            err_timeout <= 1'b1;
        end
    end

    // MEM/WB register: inserts a bubble while stalled or flushed, otherwise
    // captures the destination and either load data or the ALU result.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_reg_write <= 1'b0;
            wb_wsel      <= '0;
            wb_wdat      <= '0;
        end else if (stall || flush) begin
            wb_reg_write <= 1'b0;
        end else begin
            wb_reg_write <= reg_write_in;
            wb_wsel      <= reg_dst_in;
            wb_wdat      <= mem_to_reg_in ? dmemload : alu_output_in;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_mem_access_unit;

    localparam int WW = 32;
    localparam int RW = 5;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          flush, rdIn, wrIn, m2rIn, rwIn, dhit;
    logic [WW-1:0] addrIn, storeIn, loadIn;
    logic [RW-1:0] dstIn;
    logic          dmemREN, dmemWEN, stall, wb_reg_write, err_timeout;
    logic [WW-1:0] dmemaddr, dmemstore, wb_wdat;
    logic [RW-1:0] wb_wsel;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic          mRegWrite;
    logic [RW-1:0] mSel;
    logic [WW-1:0] mDat;
    logic          mErr;
    int            stallStreak;

    mem_access_unit #(.WORD_W(WW), .REGSEL_W(RW), .TIMEOUT(TO)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .flush        (flush),
        .mem_read_in  (rdIn),
        .mem_write_in (wrIn),
        .mem_to_reg_in(m2rIn),
        .reg_write_in (rwIn),
        .alu_output_in(addrIn),
        .rdat2_in     (storeIn),
        .reg_dst_in   (dstIn),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .dhit         (dhit),
        .dmemload     (loadIn),
        .stall        (stall),
        .wb_reg_write (wb_reg_write),
        .wb_wsel      (wb_wsel),
        .wb_wdat      (wb_wdat),
        .err_timeout  (err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic expReq();
        return (rdIn | wrIn) & ~flush;
    endfunction

    function automatic logic expStall();
        return expReq() & ~dhit;
    endfunction

    task automatic modelReset();
        mRegWrite   = 1'b0;
        mSel        = '0;
        mDat        = '0;
        mErr        = 1'b0;
        stallStreak = 0;
    endtask

    // One clock edge of the reference model: counts consecutive stalled cycles
    // and moves the instruction (or a bubble) into writeback.
    task automatic modelEdge();
        if (expStall()) stallStreak = (stallStreak < TO) ? stallStreak + 1 : TO;
        else            stallStreak = 0;
        if (stallStreak >= TO) mErr = 1'b1;
        if (expStall() || flush) begin
            mRegWrite = 1'b0;
        end else begin
            mRegWrite = rwIn;
            mSel      = dstIn;
            mDat      = m2rIn ? loadIn : addrIn;
        end
    endtask

    task automatic checkCycle();
        checkOutput("dmemREN",      32'(dmemREN),      32'(expReq() & rdIn & ~wrIn));
        checkOutput("dmemWEN",      32'(dmemWEN),      32'(expReq() & wrIn));
        checkOutput("stall",        32'(stall),        32'(expStall()));
        checkOutput("dmemaddr",     dmemaddr,          addrIn);
        checkOutput("dmemstore",    dmemstore,         storeIn);
        checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(mRegWrite));
        checkOutput("wb_wsel",      32'(wb_wsel),      32'(mSel));
        checkOutput("wb_wdat",      wb_wdat,           mDat);
        checkOutput("err_timeout",  32'(err_timeout),  32'(mErr));
    endtask

    // Drive one cycle of inputs (called just after a rising edge), check at the
    // falling edge, then advance the model at the next rising edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic m2r, input logic rw,
                                 input logic [WW-1:0] addr, input logic [WW-1:0] st,
                                 input logic [RW-1:0] dst, input logic hit,
                                 input logic [WW-1:0] load, input logic fl);
        rdIn = rd; wrIn = wr; m2rIn = m2r; rwIn = rw;
        addrIn = addr; storeIn = st; dstIn = dst;
        dhit = hit; loadIn = load; flush = fl;
        @(negedge CLK);
        checkCycle();
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, '0, '0, '0, 0, '0, 0);
    endtask

    // Reset asserted while inputs still present a read: everything must drop at once.
    task automatic resetMidCycle();
        nRST = 1'b0;
        #1;
        checkOutput("rst_dmemREN",      32'(dmemREN),      32'd0);
        checkOutput("rst_stall",        32'(stall),        32'd0);
        checkOutput("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        checkOutput("rst_wb_wsel",      32'(wb_wsel),      32'd0);
        checkOutput("rst_wb_wdat",      wb_wdat,           32'd0);
        checkOutput("rst_err_timeout",  32'(err_timeout),  32'd0);
        modelReset();
        rdIn = 0; wrIn = 0; m2rIn = 0; rwIn = 0; addrIn = '0; storeIn = '0;
        dstIn = '0; dhit = 0; loadIn = '0; flush = 0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        rdIn = 0; wrIn = 0; m2rIn = 0; rwIn = 0; addrIn = '0; storeIn = '0;
        dstIn = '0; dhit = 0; loadIn = '0; flush = 0;
        modelReset();
        #2;
        checkOutput("reset_wb_reg_write", 32'(wb_reg_write), 32'd0);
        checkOutput("reset_err_timeout",  32'(err_timeout),  32'd0);
        checkOutput("reset_stall",        32'(stall),        32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        modelEdge();
        #1;

        $display("[TB] Load hit");
        applyStimulus(1, 0, 1, 1, 32'h100, '0, 5'd5, 1, 32'hDEADBEEF, 0);
        checkOutput("t1_wb_reg_write", 32'(wb_reg_write), 32'd1);
        checkOutput("t1_wb_wsel",      32'(wb_wsel),      32'd5);
        checkOutput("t1_wb_wdat",      wb_wdat,           32'hDEADBEEF);
        idleCycle();

        $display("[TB] Store with three wait cycles");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h40, 32'h1234, 5'd0, (i == 3), 32'h0, 0);
            checkOutput("t2_wb_reg_write", 32'(wb_reg_write), 32'd0);
        end
        idleCycle();

        $display("[TB] ALU op");
        applyStimulus(0, 0, 0, 1, 32'h55, '0, 5'd9, 0, 32'hFFFF_FFFF, 0);
        checkOutput("t3_wb_wdat", wb_wdat,          32'h55);
        checkOutput("t3_wb_wsel", 32'(wb_wsel),     32'd9);
        idleCycle();

        $display("[TB] Timeout");
        for (int i = 0; i < TO + 2; i++) begin
            applyStimulus(1, 0, 1, 1, 32'h200, '0, 5'd3, 0, 32'h0, 0);
            if (i == TO - 2) checkOutput("t4_err_before", 32'(err_timeout), 32'd0);
        end
        checkOutput("t4_err_set", 32'(err_timeout), 32'd1);
        checkOutput("t4_stall",   32'(stall),       32'd1);
        applyStimulus(1, 0, 1, 1, 32'h200, '0, 5'd3, 1, 32'hCAFE0001, 0);
        checkOutput("t4_err_sticky", 32'(err_timeout), 32'd1);
        checkOutput("t4_wb_wdat",    wb_wdat,          32'hCAFE0001);
        idleCycle();

        $display("[TB] Flush in WAIT");
        applyStimulus(1, 0, 1, 1, 32'h300, '0, 5'd7, 0, 32'h0, 0);
        applyStimulus(1, 0, 1, 1, 32'h300, '0, 5'd7, 0, 32'h0, 1);
        checkOutput("t5_wb_reg_write", 32'(wb_reg_write), 32'd0);
        idleCycle();

        $display("[TB] Reset mid-WAIT");
        applyStimulus(1, 0, 1, 1, 32'h400, '0, 5'd2, 0, 32'h0, 0);
        applyStimulus(1, 0, 1, 1, 32'h400, '0, 5'd2, 0, 32'h0, 0);
        rdIn = 1; m2rIn = 1; rwIn = 1; addrIn = 32'h400; dstIn = 5'd2;
        resetMidCycle();

        $display("[TB] Random traffic");
        for (int i = 0; i < 400; i++) begin
            logic hitBias;
            hitBias = (i % 100) < 60;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, 5'($urandom),
                          hitBias ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0),
                          $urandom, ($urandom_range(0, 9) == 0));
            if (i == 200) begin
                rdIn = 1;
                resetMidCycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
